// File: rtl/multiplier_ctrl_v5.sv
// multiplier_ctrl_v5: sequencing controller for the byte-sliced RV32M multiplier datapath.
// Accepts one MUL/MULH/MULHSU/MULHU request, then steps the datapath through
// clear, load, four rotate-and-accumulate passes and a two-cycle pipeline flush.
// After that it returns the result over a valid/ready handshake.
// Optional feature: define MUL_ZERO_BYPASS_EN to short-circuit operations
// with a zero operand straight to DONE without touching the datapath.
module multiplier_ctrl_v5 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  input  logic        kill_i,
  output logic        dp_rst_o,
  output logic [31:0] dp_op_a_o,
  output logic [31:0] dp_op_b_o,
  output logic        dp_upper_o,
  output logic        dp_signed_a_o,
  output logic        dp_signed_b_o,
  output logic        dp_reg_a_en_o,
  output logic        dp_reg_b_en_o,
  output logic        dp_ac_en_o,
  output logic        dp_en_pipe_o,
  output logic        dp_mux_b_sel_o,
  output logic        dp_rol_en_o,
  output logic [1:0]  dp_shift_amount_o,
  input  logic [31:0] dp_result_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_PASS,
    ST_FLUSH1,
    ST_FLUSH2,
    ST_DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  pass_cnt_q;
  logic [1:0]  pass_cnt_d;
  logic        accept;
  logic        zero_hit;
  logic        clr_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        upper_q;
  logic        signed_a_q;
  logic        signed_b_q;
  logic        dec_upper;
  logic        dec_signed_a;
  logic        dec_signed_b;

`ifdef MUL_ZERO_BYPASS_EN
  logic        zero_q;

  assign zero_hit = (req_a_i == 32'd0) || (req_b_i == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  // Next-state logic: fixed walk through the sequence; kill aborts from any busy state
  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = zero_hit ? ST_DONE : ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d    = ST_PASS;
        pass_cnt_d = 2'd0;
      end
      ST_PASS: begin
        if (pass_cnt_q == 2'd3) begin
          state_d = ST_FLUSH1;
        end else begin
          pass_cnt_d = pass_cnt_q + 2'd1;
        end
      end
      ST_FLUSH1: begin
        state_d = ST_FLUSH2;
      end
      ST_FLUSH2: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (kill_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // State and pass counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pass_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  // Datapath clear is a registered copy of "entering CLR" so dp_rst_o never glitches
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_q <= 1'b0;
    end else begin
      clr_q <= (state_d == ST_CLR);
    end
  end

  // Opcode decode into upper-word select and operand signedness
  always_comb begin
    dec_upper    = 1'b0;
    dec_signed_a = 1'b0;
    dec_signed_b = 1'b0;
    case (req_op_i)
      2'b00: begin
        dec_upper    = 1'b0;
        dec_signed_a = 1'b0;
        dec_signed_b = 1'b0;
      end
      2'b01: begin
        dec_upper    = 1'b1;
        dec_signed_a = 1'b1;
        dec_signed_b = 1'b1;
      end
      2'b10: begin
        dec_upper    = 1'b1;
        dec_signed_a = 1'b1;
        dec_signed_b = 1'b0;
      end
      default: begin
        dec_upper    = 1'b1;
        dec_signed_a = 1'b0;
        dec_signed_b = 1'b0;
      end
    endcase
  end

  // Operands and decode are captured on accept; a bypassed request leaves them alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      upper_q    <= 1'b0;
      signed_a_q <= 1'b0;
      signed_b_q <= 1'b0;
    end else if (accept && !zero_hit) begin
      op_a_q     <= req_a_i;
      op_b_q     <= req_b_i;
      upper_q    <= dec_upper;
      signed_a_q <= dec_signed_a;
      signed_b_q <= dec_signed_b;
    end
  end

`ifdef MUL_ZERO_BYPASS_EN
  // Remember whether the current result must be forced to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= zero_hit;
    end
  end
`endif

  // Datapath strobes decoded purely from the state register and pass counter
  always_comb begin
    dp_reg_a_en_o     = 1'b0;
    dp_reg_b_en_o     = 1'b0;
    dp_ac_en_o        = 1'b0;
    dp_en_pipe_o      = 1'b0;
    dp_mux_b_sel_o    = 1'b0;
    dp_rol_en_o       = 1'b0;
    dp_shift_amount_o = 2'b00;
    case (state_q)
      ST_LOAD: begin
        dp_reg_a_en_o = 1'b1;
        dp_reg_b_en_o = 1'b1;
      end
      ST_PASS: begin
        dp_en_pipe_o = 1'b1;
        dp_ac_en_o   = 1'b1;
        case (pass_cnt_q)
          2'd0:    dp_shift_amount_o = 2'b00;
          2'd1:    dp_shift_amount_o = 2'b01;
          2'd2:    dp_shift_amount_o = 2'b11;
          default: dp_shift_amount_o = 2'b10;
        endcase
        if (pass_cnt_q != 2'd3) begin
          dp_reg_b_en_o  = 1'b1;
          dp_mux_b_sel_o = 1'b1;
          dp_rol_en_o    = 1'b1;
        end
      end
      ST_FLUSH1: begin
        dp_en_pipe_o = 1'b1;
        dp_ac_en_o   = 1'b1;
      end
      ST_FLUSH2: begin
        dp_en_pipe_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Handshake outputs; result data is gated to zero outside DONE
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) && !rst_i;
    res_valid_o = (state_q == ST_DONE);
    res_data_o  = 32'd0;
    if (state_q == ST_DONE) begin
`ifdef MUL_ZERO_BYPASS_EN
      res_data_o = zero_q ? 32'd0 : dp_result_i;
`else
      res_data_o = dp_result_i;
`endif
    end
  end

  assign dp_rst_o      = rst_i | clr_q;
  assign dp_op_a_o     = op_a_q;
  assign dp_op_b_o     = op_b_q;
  assign dp_upper_o    = upper_q;
  assign dp_signed_a_o = signed_a_q;
  assign dp_signed_b_o = signed_b_q;

endmodule

// File: tb/tb_multiplier_ctrl_v5.sv
// Testbench for multiplier_ctrl_v5: drives requests, stands in for the datapath
// by presenting the architecturally correct product on dp_result_i, and
// compares handshakes, latency and per-cycle strobes against a cycle-table model.
// Honours MUL_ZERO_BYPASS_EN when the design is built with it.
module tb_multiplier_ctrl_v5;

  localparam int MAXC = 25;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic        kill_i;
  logic        dp_rst_o;
  logic [31:0] dp_op_a_o;
  logic [31:0] dp_op_b_o;
  logic        dp_upper_o;
  logic        dp_signed_a_o;
  logic        dp_signed_b_o;
  logic        dp_reg_a_en_o;
  logic        dp_reg_b_en_o;
  logic        dp_ac_en_o;
  logic        dp_en_pipe_o;
  logic        dp_mux_b_sel_o;
  logic        dp_rol_en_o;
  logic [1:0]  dp_shift_amount_o;
  logic [31:0] dp_result_i;

  int checks = 0;
  int passed = 0;

  logic [8:0]   tr_strobe [0:31];
  logic         tr_valid  [0:31];
  logic [31:0]  tr_data   [0:31];
  logic         tr_ready  [0:31];
  logic [2:0]   tr_dec    [0:31];
  logic [31:0]  tr_opa    [0:31];
  logic [31:0]  tr_opb    [0:31];
  logic         hold_valid [0:7];
  logic [31:0]  hold_data  [0:7];
  logic         hold_ready [0:7];
  logic [109:0] rst_snap;
  int           lat;
  logic         ready_after;
  longint       accept_time;

  multiplier_ctrl_v5 dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_a_i           (req_a_i),
    .req_b_i           (req_b_i),
    .res_valid_o       (res_valid_o),
    .res_ready_i       (res_ready_i),
    .res_data_o        (res_data_o),
    .kill_i            (kill_i),
    .dp_rst_o          (dp_rst_o),
    .dp_op_a_o         (dp_op_a_o),
    .dp_op_b_o         (dp_op_b_o),
    .dp_upper_o        (dp_upper_o),
    .dp_signed_a_o     (dp_signed_a_o),
    .dp_signed_b_o     (dp_signed_b_o),
    .dp_reg_a_en_o     (dp_reg_a_en_o),
    .dp_reg_b_en_o     (dp_reg_b_en_o),
    .dp_ac_en_o        (dp_ac_en_o),
    .dp_en_pipe_o      (dp_en_pipe_o),
    .dp_mux_b_sel_o    (dp_mux_b_sel_o),
    .dp_rol_en_o       (dp_rol_en_o),
    .dp_shift_amount_o (dp_shift_amount_o),
    .dp_result_i       (dp_result_i)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  // Architectural RV32M result from 64-bit arithmetic on extended operands
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as_, au, bs, bu, p;
    as_ = {{32{a[31]}}, a};
    au  = {32'd0, a};
    bs  = {{32{b[31]}}, b};
    bu  = {32'd0, b};
    case (op)
      2'b00:   p = au * bu;
      2'b01:   p = as_ * bs;
      2'b10:   p = as_ * bu;
      default: p = au * bu;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Expected {upper, signedA, signedB} per opcode
  function automatic logic [2:0] ref_decode(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b000;
      2'b01:   return 3'b111;
      2'b10:   return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  // Expected {dp_rst, regA, regB, ac, pipe, muxB, rol, shift[1:0]} for cycle c after accept
  function automatic logic [8:0] ref_strobe(input int c);
    logic r, ra, rb, ac, pp, mx, rl;
    logic [1:0] sh;
    int k;
    {r, ra, rb, ac, pp, mx, rl} = 7'b0;
    sh = 2'b00;
    if (c == 1) r = 1'b1;
    if (c == 2) begin ra = 1'b1; rb = 1'b1; end
    if (c >= 3 && c <= 6) begin
      k  = c - 3;
      pp = 1'b1;
      ac = 1'b1;
      sh = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b11 : 2'b10;
      if (k < 3) begin rb = 1'b1; mx = 1'b1; rl = 1'b1; end
    end
    if (c == 7) begin pp = 1'b1; ac = 1'b1; end
    if (c == 8) pp = 1'b1;
    return {r, ra, rb, ac, pp, mx, rl, sh};
  endfunction

  // Issue one request, trace outputs cycle by cycle, optionally kill/reset/back-pressure
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int hold, input int kill_cyc, input int rst_cyc);
    int n;
    n = 0;
    lat = -1;
    for (int i = 0; i < 32; i++) begin
      tr_strobe[i] = 'x; tr_valid[i] = 'x; tr_data[i] = 'x; tr_ready[i] = 'x;
      tr_dec[i] = 'x; tr_opa[i] = 'x; tr_opb[i] = 'x;
    end
    while (req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_valid_i = 1'b1;
    dp_result_i = ref_result(op, a, b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) dp_result_i = 32'hA5A5_5A5A;
`endif
    @(posedge clk_i);
    accept_time = $time;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk_i);
      tr_strobe[c] = {dp_rst_o, dp_reg_a_en_o, dp_reg_b_en_o, dp_ac_en_o, dp_en_pipe_o,
                      dp_mux_b_sel_o, dp_rol_en_o, dp_shift_amount_o};
      tr_valid[c]  = res_valid_o;
      tr_data[c]   = res_data_o;
      tr_ready[c]  = req_ready_o;
      tr_dec[c]    = {dp_upper_o, dp_signed_a_o, dp_signed_b_o};
      tr_opa[c]    = dp_op_a_o;
      tr_opb[c]    = dp_op_b_o;
      if (c == 1) begin
        req_valid_i = 1'b0;
        req_a_i     = $urandom;
        req_b_i     = $urandom;
        req_op_i    = 2'($urandom_range(0, 3));
      end
      if (kill_i) kill_i = 1'b0;
      if (c == kill_cyc) kill_i = 1'b1;
      if (c == rst_cyc) begin
        rst_i = 1'b1;
        #1;
        rst_snap = {req_ready_o, res_valid_o, res_data_o, dp_op_a_o, dp_op_b_o,
                    dp_upper_o, dp_signed_a_o, dp_signed_b_o,
                    dp_rst_o, dp_reg_a_en_o, dp_reg_b_en_o, dp_ac_en_o, dp_en_pipe_o,
                    dp_mux_b_sel_o, dp_rol_en_o, dp_shift_amount_o};
        #2;
        rst_i = 1'b0;
      end
      if (tr_valid[c] === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk_i);
        hold_valid[h] = res_valid_o;
        hold_data[h]  = res_data_o;
        hold_ready[h] = req_ready_o;
      end
      res_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      res_ready_i = 1'b0;
    end
    ready_after = req_ready_o;
  endtask

  task automatic test_reset();
    logic [109:0] snap, exp_snap;
    @(negedge clk_i);
    snap = {req_ready_o, res_valid_o, res_data_o, dp_op_a_o, dp_op_b_o,
            dp_upper_o, dp_signed_a_o, dp_signed_b_o,
            dp_rst_o, dp_reg_a_en_o, dp_reg_b_en_o, dp_ac_en_o, dp_en_pipe_o,
            dp_mux_b_sel_o, dp_rol_en_o, dp_shift_amount_o};
    exp_snap = '0;
    exp_snap[8] = 1'b1;
    checks++;
    if (snap !== exp_snap) $display("[TB] FAIL reset_outputs: got %h expected %h", snap, exp_snap);
    else passed++;
    rst_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o);
    else passed++;
    checks++;
    if (dp_rst_o !== 1'b0) $display("[TB] FAIL reset_dp_rst: got %b expected 0", dp_rst_o);
    else passed++;
    @(negedge clk_i);
  endtask

  task automatic test_mul_basic();
    logic [1:0] sh_exp [0:3];
    logic       stale;
    sh_exp = '{2'b00, 2'b01, 2'b11, 2'b10};
    apply_stimulus(2'b00, 32'd7, 32'd6, 0, 0, 0);
    checks++;
    if (lat !== 9) $display("[TB] FAIL mul_latency: got %0d expected 9", lat);
    else passed++;
    checks++;
    if (tr_data[9] !== ref_result(2'b00, 32'd7, 32'd6))
      $display("[TB] FAIL mul_data: got %h expected %h", tr_data[9], ref_result(2'b00, 32'd7, 32'd6));
    else passed++;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (tr_strobe[c] !== ref_strobe(c))
        $display("[TB] FAIL mul_strobe_c%0d: got %b expected %b", c, tr_strobe[c], ref_strobe(c));
      else passed++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tr_strobe[3 + k][1:0] !== sh_exp[k])
        $display("[TB] FAIL mul_shift_k%0d: got %b expected %b", k, tr_strobe[3 + k][1:0], sh_exp[k]);
      else passed++;
    end
    stale = 1'b0;
    for (int c = 1; c <= 8; c++) if (tr_data[c] !== 32'd0 || tr_valid[c] !== 1'b0 || tr_ready[c] !== 1'b0) stale = 1'b1;
    checks++;
    if (stale !== 1'b0) $display("[TB] FAIL mul_busy_outputs: got %b expected 0", stale);
    else passed++;
    checks++;
    if (tr_opa[2] !== 32'd7 || tr_opb[2] !== 32'd6)
      $display("[TB] FAIL mul_operands: got %h/%h expected 7/6", tr_opa[2], tr_opb[2]);
    else passed++;
    checks++;
    if (ready_after !== 1'b1) $display("[TB] FAIL mul_ready_after: got %b expected 1", ready_after);
    else passed++;
  endtask

  task automatic test_upper();
    logic [1:0]  ops [0:2];
    logic [31:0] as_ [0:2];
    logic [31:0] bs  [0:2];
    ops = '{2'b01, 2'b11, 2'b10};
    as_ = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(ops[i], as_[i], bs[i], 0, 0, 0);
      checks++;
      if (lat !== 9) $display("[TB] FAIL upper%0d_latency: got %0d expected 9", i, lat);
      else passed++;
      checks++;
      if (tr_data[9] !== ref_result(ops[i], as_[i], bs[i]))
        $display("[TB] FAIL upper%0d_data: got %h expected %h", i, tr_data[9], ref_result(ops[i], as_[i], bs[i]));
      else passed++;
      checks++;
      if (tr_dec[2] !== ref_decode(ops[i]))
        $display("[TB] FAIL upper%0d_decode: got %b expected %b", i, tr_dec[2], ref_decode(ops[i]));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    apply_stimulus(2'b00, 32'h0001_0000, 32'h0001_0000, 3, 0, 0);
    checks++;
    if (lat !== 9) $display("[TB] FAIL bp_latency: got %0d expected 9", lat);
    else passed++;
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (hold_valid[h] !== 1'b1 || hold_data[h] !== ref_result(2'b00, 32'h0001_0000, 32'h0001_0000) || hold_ready[h] !== 1'b0)
        $display("[TB] FAIL bp_hold%0d: got v=%b d=%h r=%b expected v=1 d=%h r=0", h, hold_valid[h], hold_data[h],
                 hold_ready[h], ref_result(2'b00, 32'h0001_0000, 32'h0001_0000));
      else passed++;
    end
    apply_stimulus(2'b00, 32'd3, 32'd3, 0, 0, 0);
    checks++;
    if (lat !== 9 || tr_data[9] !== 32'd9) $display("[TB] FAIL bp_next: got lat=%0d d=%h expected lat=9 d=9", lat, tr_data[9]);
    else passed++;
  endtask

  task automatic test_kill();
    apply_stimulus(2'b00, 32'h0000_1234, 32'h0000_0055, 0, 4, 0);
    checks++;
    if (tr_strobe[4] !== ref_strobe(4)) $display("[TB] FAIL kill_pass1: got %b expected %b", tr_strobe[4], ref_strobe(4));
    else passed++;
    checks++;
    if (lat !== -1) $display("[TB] FAIL kill_no_valid: got %0d expected -1", lat);
    else passed++;
    checks++;
    if (tr_ready[5] !== 1'b1 || tr_strobe[5] !== 9'd0)
      $display("[TB] FAIL kill_idle: got r=%b s=%b expected r=1 s=0", tr_ready[5], tr_strobe[5]);
    else passed++;
    apply_stimulus(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    checks++;
    if (lat !== 9 || tr_data[9] !== ref_result(2'b11, 32'h1234_5678, 32'h9ABC_DEF0))
      $display("[TB] FAIL kill_next: got lat=%0d d=%h expected lat=9 d=%h", lat, tr_data[9],
               ref_result(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
    else passed++;
  endtask

  task automatic test_reset_recovery();
    logic [109:0] exp_snap;
    exp_snap = '0;
    exp_snap[8] = 1'b1;
    apply_stimulus(2'b01, 32'hDEAD_0001, 32'h0000_7777, 0, 0, 7);
    checks++;
    if (rst_snap !== exp_snap) $display("[TB] FAIL rst_mid_outputs: got %h expected %h", rst_snap, exp_snap);
    else passed++;
    checks++;
    if (lat !== -1 || tr_ready[8] !== 1'b1) $display("[TB] FAIL rst_mid_idle: got lat=%0d r=%b expected lat=-1 r=1", lat, tr_ready[8]);
    else passed++;
    apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    checks++;
    if (lat !== 9 || tr_data[9] !== 32'hFFFF_FFFE)
      $display("[TB] FAIL rst_next: got lat=%0d d=%h expected lat=9 d=fffffffe", lat, tr_data[9]);
    else passed++;
    checks++;
    if (tr_strobe[1] !== ref_strobe(1) || tr_dec[2] !== 3'b000)
      $display("[TB] FAIL rst_next_seq: got s=%b dec=%b expected s=%b dec=000", tr_strobe[1], tr_dec[2], ref_strobe(1));
    else passed++;
  endtask

  task automatic test_zero();
    logic [31:0] opa_before;
    opa_before = dp_op_a_o;
    apply_stimulus(2'b00, 32'd0, 32'h1234_5678, 0, 0, 0);
`ifdef MUL_ZERO_BYPASS_EN
    checks++;
    if (lat !== 1) $display("[TB] FAIL zero_latency: got %0d expected 1", lat);
    else passed++;
    checks++;
    if (tr_strobe[1] !== 9'd0 || tr_opa[1] !== opa_before)
      $display("[TB] FAIL zero_untouched: got s=%b a=%h expected s=0 a=%h", tr_strobe[1], tr_opa[1], opa_before);
    else passed++;
    checks++;
    if (tr_data[1] !== 32'd0) $display("[TB] FAIL zero_data: got %h expected 0", tr_data[1]);
    else passed++;
`else
    checks++;
    if (lat !== 9) $display("[TB] FAIL zero_latency: got %0d expected 9 (prev a=%h)", lat, opa_before);
    else passed++;
    checks++;
    if (tr_data[9] !== 32'd0) $display("[TB] FAIL zero_data: got %h expected 0", tr_data[9]);
    else passed++;
    checks++;
    if (tr_opa[2] !== 32'd0) $display("[TB] FAIL zero_operand: got %h expected 0", tr_opa[2]);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    longint      prev_time;
    logic        strobe_bad;
    prev_time = -1;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom | 32'h1;
      b  = $urandom | 32'h1;
      apply_stimulus(op, a, b, 0, 0, 0);
      checks++;
      if (lat !== 9 || tr_data[9] !== ref_result(op, a, b))
        $display("[TB] FAIL b2b%0d_result: got lat=%0d d=%h expected lat=9 d=%h", i, lat, tr_data[9], ref_result(op, a, b));
      else passed++;
      checks++;
      if (tr_dec[2] !== ref_decode(op) || tr_opa[2] !== a || tr_opb[2] !== b)
        $display("[TB] FAIL b2b%0d_capture: got dec=%b a=%h b=%h expected dec=%b a=%h b=%h", i, tr_dec[2], tr_opa[2],
                 tr_opb[2], ref_decode(op), a, b);
      else passed++;
      strobe_bad = 1'b0;
      for (int c = 1; c <= 9; c++) if (tr_strobe[c] !== ref_strobe(c)) strobe_bad = 1'b1;
      checks++;
      if (strobe_bad !== 1'b0) $display("[TB] FAIL b2b%0d_strobes: got %b expected 0", i, strobe_bad);
      else passed++;
      if (prev_time >= 0) begin
        checks++;
        if (accept_time - prev_time != 100)
          $display("[TB] FAIL b2b%0d_throughput: got %0d expected 100", i, accept_time - prev_time);
        else passed++;
      end
      prev_time = accept_time;
    end
  endtask

  // Test sequence
  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = 2'b00;
    req_a_i     = 32'd0;
    req_b_i     = 32'd0;
    res_ready_i = 1'b0;
    kill_i      = 1'b0;
    dp_result_i = 32'h5555_AAAA;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_mul_basic();
    test_upper();
    test_backpressure();
    test_kill();
    test_reset_recovery();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_ctrl_v5.md
# multiplier_ctrl_v5

Sequencing controller for the 4-lane byte-sliced RV32M multiplier datapath (`multiplier_DP_V5`). It accepts one MUL/MULH/MULHSU/MULHU request at a time over a valid/ready handshake. It registers the operands and drives every datapath control strobe through clear, load, four rotate-and-accumulate passes and pipeline flush. It then returns the 32-bit result over a second valid/ready handshake. It sits between the execute-stage issue logic and the datapath instance.

## Interface
- No parameters.
- `clk_i` in 1: clock; all flops rise-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: high only in IDLE.
- `req_op_i` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_a_i`, `req_b_i` in 32: operands (rs1, rs2).
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result consumed.
- `res_data_o` out 32: result.
- `kill_i` in 1: abort current operation (pipeline flush).
- `dp_rst_o` out 1: datapath reset, equal to `rst_i | clr_q`.
- `dp_op_a_o`, `dp_op_b_o` out 32: registered operands.
- `dp_upper_o`, `dp_signed_a_o`, `dp_signed_b_o` out 1: operation decode.
- `dp_reg_a_en_o`, `dp_reg_b_en_o`, `dp_ac_en_o`, `dp_en_pipe_o`, `dp_mux_b_sel_o`, `dp_rol_en_o` out 1: datapath strobes.
- `dp_shift_amount_o` out 2: shifter select.
- `dp_result_i` in 32: datapath accumulator.

## Operation
- All outputs reset to 0; `req_ready_o` is 1 once `rst_i` deasserts (IDLE).
- Decode, latched on accept:
  - MUL: upper=0, sA=0, sB=0.
  - MULH: upper=1, sA=1, sB=1.
  - MULHSU: upper=1, sA=1, sB=0.
  - MULHU: upper=1, sA=0, sB=0.
- **IDLE**: on `req_valid_i`, register operands and decode, then go to CLR.
- **CLR** (1 cycle): `clr_q`=1 resets the datapath, clearing the accumulator and pipeline. All strobes are 0.
- **LOAD** (1 cycle):
  - `reg_a_en`=1, `reg_b_en`=1, `mux_b_sel`=0, `rol_en`=0.
  - upper/signed outputs are driven with the latched decode.
- **PASS**: 2-bit counter k=0..3.
  - `en_pipe`=1, `ac_en`=1, `reg_a_en`=0 (mandatory, so the datapath rotates the sign-flag vector instead of reloading).
  - `shift_amount` is k=0→00, 1→01, 2→11, 3→10.
  - k=0..2: `reg_b_en`=1, `mux_b_sel`=1, `rol_en`=1.
  - k=3: B strobes are 0.
- **FLUSH1**: `en_pipe`=1, `ac_en`=1.
- **FLUSH2**: `en_pipe`=1, `ac_en`=0. This drains the delayed accumulate-enable so no further accumulation occurs.
- **DONE**:
  - All strobes are 0 and `res_valid_o`=1.
  - `res_data_o`=`dp_result_i`, stable because the accumulator is frozen.
  - On `res_ready_i`, go to IDLE.
- Outside DONE, `res_data_o` is 0.
- `kill_i` in any non-IDLE state returns to IDLE next edge; the result is dropped and `res_valid_o` is never raised. `kill_i` outranks `res_ready_i`.
- Asynchronous reset mid-operation: immediately IDLE, outputs 0, `dp_rst_o`=1. The next request behaves exactly like the first after power-up.
- No request is accepted outside IDLE; no result is skipped.

## Timing
- Accept at edge of cycle 0:
  - CLR = cycle 1, LOAD = 2, PASS0–3 = 3–6, FLUSH1 = 7, FLUSH2 = 8.
  - `res_valid_o`=1 from cycle 9 until handshake.
- Fixed latency of 9 cycles accept→valid; throughput of one operation per 10 cycles with `res_ready_i` tied high.
- Next accept is possible in the cycle after the result handshake.
- `clr_q` is a flop; `dp_rst_o` is glitch-free apart from `rst_i` itself.
- All `dp_*` strobes are decoded from the state register only; no combinational path from `req_*` to `dp_*`.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined:
  - If `req_a_i`==0 or `req_b_i`==0 at accept, go straight to DONE with `res_data_o` forced to 0 from an internal flag.
  - The datapath is untouched. Result valid in cycle 1.
- Undefined: the zero check and flag are absent; every operation takes 9 cycles.

## Test plan
- MUL 7×6: `res_valid_o` rises in cycle 9 with `res_data_o`=0x0000002A; `shift_amount` sequence in cycles 3–6 is 00,01,11,10.
- Upper-word variants, each with `res_valid_o` in cycle 9:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU 0x80000000×0x00000002 → 0xFFFFFFFF.
- Result backpressure:
  - MUL 0x10000×0x10000 (→0x00000000) with `res_ready_i` low for 3 cycles: data and valid are held; `req_ready_o` stays 0.
  - Then MUL 3×3 → 0x00000009 (no stale accumulation).
- Abort and reset recovery:
  - `kill_i` in PASS1: IDLE next cycle, no `res_valid_o`; following MULHU 0x12345678×0x9ABCDEF0 → 0x0B00EA4E.
  - `rst_i` pulse in FLUSH1: all outputs 0, `dp_rst_o`=1; following MUL 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Zero bypass, MUL 0×0x12345678:
  - With `MUL_ZERO_BYPASS_EN`: result 0 in cycle 1, no `dp_*` strobe toggles.
  - Without it: result 0 in cycle 9.
